// File: rtl/ifetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: fetch FSM states and
// byte-address width derivation.
package ifetch_queue_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    // Memory is sized in halfwords; the fetch address is a byte address.
    function automatic int addr_width_f(input int mem_depth);
        return $clog2(mem_depth * 2);
    endfunction

endpackage

// File: rtl/ifetch_queue_ir_fifo.sv
// Show-ahead instruction queue: head entry is visible combinationally, reads
// as zero when empty, and a flush empties it regardless of push/pop.
module ir_fifo
    import ifetch_queue_pkg::*;
#(
    parameter int QDEPTH = 4,
    parameter int DATA_W = 29
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic [DATA_W-1:0]            push_data,
    input  logic                         pop,
    output logic [DATA_W-1:0]            head_data,
    output logic                         head_vld,
    output logic [$clog2(QDEPTH+1)-1:0]  count
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);

    logic [DATA_W-1:0] mem [QDEPTH];
    logic [PW:0]       wr_ptr;
    logic [PW:0]       rd_ptr;
    logic              do_pop;

    assign do_pop = pop && head_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr[PW-1:0]] <= push_data;
    end

    assign head_vld  = (wr_ptr != rd_ptr);
    assign count     = CW'(wr_ptr - rd_ptr);
    assign head_data = head_vld ? mem[rd_ptr[PW-1:0]] : '0;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch unit: issues halfword reads to a 1-cycle-latency memory and
// buffers the returned instructions with their byte addresses for decode.
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int MEM_DEPTH = 2**12,
    parameter int QDEPTH    = 4,
    parameter int RESET_PC  = 0,
    localparam int ADDR_WIDTH = addr_width_f(MEM_DEPTH),
    localparam int CW         = $clog2(QDEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic                  i_mem_gnt,
    input  logic [0:1][7:0]       i_mem_do,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_en,
    output logic                  o_mem_rd_en,
    input  logic                  i_redirect,
    input  logic [ADDR_WIDTH-1:0] i_redirect_addr,
    input  logic                  i_ir_ready,
    output logic [15:0]           o_ir,
    output logic [ADDR_WIDTH-1:0] o_ir_pc,
    output logic                  o_ir_valid,
    output logic [CW-1:0]         o_count
);

    fetch_state_e           state_q;
    fetch_state_e           state_d;
    logic [ADDR_WIDTH-1:0]  fetch_addr_q;
    logic                   issue_p0;
    logic                   rd_vld_p1;
    logic [ADDR_WIDTH-1:0]  rd_addr_p1;
    logic                   push_p1;
    logic [CW:0]            occupancy;
    logic [ADDR_WIDTH+15:0] head_data;
    logic                   unused_redirect_lsb;

    assign unused_redirect_lsb = i_redirect_addr[0];

    // Stage p0: issue. Space is reserved for the read still in flight.
    assign occupancy = {1'b0, o_count} + (CW+1)'(rd_vld_p1);
    assign issue_p0  = (state_q == FETCH) && i_en && i_mem_gnt && !i_redirect
                       && (occupancy < (CW+1)'(QDEPTH));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_en) state_d = FETCH;
            FETCH:   if (!i_en && !rd_vld_p1) state_d = IDLE;
            FLUSH:   state_d = i_en ? FETCH : IDLE;
            default: state_d = IDLE;
        endcase
        if (i_redirect && rd_vld_p1)
            state_d = FLUSH;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            fetch_addr_q <= ADDR_WIDTH'(RESET_PC);
            rd_vld_p1    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_vld_p1 <= issue_p0;
            if (i_redirect)
                fetch_addr_q <= {i_redirect_addr[ADDR_WIDTH-1:1], 1'b0};
            else if (issue_p0)
                fetch_addr_q <= fetch_addr_q + ADDR_WIDTH'(2);
        end
    end

    always_ff @(posedge clk) begin
        if (issue_p0)
            rd_addr_p1 <= fetch_addr_q;
    end

    // Stage p1: memory data returns; a redirect or flush discards it.
    assign push_p1 = rd_vld_p1 && (state_q != FLUSH) && !i_redirect;

    ir_fifo #(
        .QDEPTH (QDEPTH),
        .DATA_W (16 + ADDR_WIDTH)
    ) u_ir_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (i_redirect),
        .push      (push_p1),
        .push_data ({i_mem_do[0], i_mem_do[1], rd_addr_p1}),
        .pop       (i_ir_ready),
        .head_data (head_data),
        .head_vld  (o_ir_valid),
        .count     (o_count)
    );

    assign o_mem_addr  = fetch_addr_q;
    assign o_mem_en    = issue_p0;
    assign o_mem_rd_en = issue_p0;
    assign o_ir        = head_data[ADDR_WIDTH+15:ADDR_WIDTH];
    assign o_ir_pc     = head_data[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with a 1-cycle-latency memory whose word at
// byte address a is 0x1111*(a/2+1), truncated to 16 bits.
module tb_ifetch_queue;

    localparam int AW = 13;

    logic           clk;
    logic           rst;
    logic           i_en;
    logic           i_mem_gnt;
    logic [0:1][7:0] i_mem_do;
    logic [AW-1:0]  o_mem_addr;
    logic           o_mem_en;
    logic           o_mem_rd_en;
    logic           i_redirect;
    logic [AW-1:0]  i_redirect_addr;
    logic           i_ir_ready;
    logic [15:0]    o_ir;
    logic [AW-1:0]  o_ir_pc;
    logic           o_ir_valid;
    logic [2:0]     o_count;

    int errors = 0;
    int checks = 0;
    int popped = 0;
    logic [AW-1:0] mem_addr_q = '0;
    logic [15:0] exp_stream [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    logic [15:0] exp_toggle [4] = '{16'h2211, 16'h3322, 16'h4433, 16'h5544};

    ifetch_queue dut (
        .clk             (clk),
        .rst             (rst),
        .i_en            (i_en),
        .i_mem_gnt       (i_mem_gnt),
        .i_mem_do        (i_mem_do),
        .o_mem_addr      (o_mem_addr),
        .o_mem_en        (o_mem_en),
        .o_mem_rd_en     (o_mem_rd_en),
        .i_redirect      (i_redirect),
        .i_redirect_addr (i_redirect_addr),
        .i_ir_ready      (i_ir_ready),
        .o_ir            (o_ir),
        .o_ir_pc         (o_ir_pc),
        .o_ir_valid      (o_ir_valid),
        .o_count         (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] word_at(input logic [AW-1:0] a);
        logic [31:0] prod;
        prod = 32'h1111 * (32'(a >> 1) + 32'd1);
        return prod[15:0];
    endfunction

    always @(posedge clk) begin
        if (o_mem_en)
            mem_addr_q <= o_mem_addr;
    end
    assign i_mem_do = word_at(mem_addr_q);

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; i_en = 1'b0; i_mem_gnt = 1'b0; i_redirect = 1'b0;
        i_redirect_addr = '0; i_ir_ready = 1'b0;
        step(); step();
        #1;
        check("rst_count", 32'(o_count), 0);
        check("rst_valid", 32'(o_ir_valid), 0);
        check("rst_ir", 32'(o_ir), 0);
        check("rst_ir_pc", 32'(o_ir_pc), 0);
        check("rst_mem_en", 32'(o_mem_en), 0);
        check("rst_rd_en", 32'(o_mem_rd_en), 0);

        // Release reset with fetch enabled; first cycle is still IDLE.
        rst = 1'b0; i_en = 1'b1; i_mem_gnt = 1'b1;
        #1;
        check("idle_no_read", 32'(o_mem_en), 0);
        step();                                   // C0
        #1;
        check("c0_mem_en", 32'(o_mem_en), 1);
        check("c0_rd_en", 32'(o_mem_rd_en), 1);
        check("c0_addr", 32'(o_mem_addr), 0);
        step();                                   // C1
        #1;
        check("c1_valid", 32'(o_ir_valid), 0);
        check("c1_addr", 32'(o_mem_addr), 2);
        step();                                   // C2
        #1;
        check("c2_valid", 32'(o_ir_valid), 1);
        check("c2_ir", 32'(o_ir), 32'h1111);
        check("c2_ir_pc", 32'(o_ir_pc), 0);
        check("c2_addr", 32'(o_mem_addr), 4);
        step(); step();                           // C4
        #1;
        check("c4_full_stop", 32'(o_mem_en), 0);
        step();                                   // C5
        #1;
        check("c5_count_full", 32'(o_count), 4);
        check("c5_mem_en", 32'(o_mem_en), 0);

        // Drain four entries while refilling.
        i_ir_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("stream_valid", 32'(o_ir_valid), 1);
            check("stream_ir", 32'(o_ir), 32'(exp_stream[k]));
            check("stream_pc", 32'(o_ir_pc), 32'(2 * k));
            check("stream_mem_en", 32'(o_mem_en), (k != 0) ? 1 : 0);
            step();
        end
        i_ir_ready = 1'b0;                        // C9
        #1;
        check("c9_ir", 32'(o_ir), 32'h5555);
        check("c9_pc", 32'(o_ir_pc), 8);
        check("c9_count", 32'(o_count), 2);
        step(); step();                           // C11
        #1;
        check("c11_count", 32'(o_count), 4);
        check("c11_mem_en", 32'(o_mem_en), 0);

        // Make one slot, issue one read, redirect while it is in flight.
        i_ir_ready = 1'b1;
        step();                                   // C12
        i_ir_ready = 1'b0;
        #1;
        check("c12_count", 32'(o_count), 3);
        check("c12_mem_en", 32'(o_mem_en), 1);
        check("c12_addr", 32'(o_mem_addr), 32'h10);
        step();                                   // C13
        i_redirect = 1'b1; i_redirect_addr = 13'h0101; i_ir_ready = 1'b1;
        #1;
        check("redir_no_read", 32'(o_mem_en), 0);
        step();                                   // C14 (flush bubble)
        i_redirect = 1'b0; i_ir_ready = 1'b0;
        #1;
        check("redir_count", 32'(o_count), 0);
        check("redir_valid", 32'(o_ir_valid), 0);
        check("flush_mem_en", 32'(o_mem_en), 0);
        step();                                   // C15
        #1;
        check("redir_mem_en", 32'(o_mem_en), 1);
        check("redir_addr", 32'(o_mem_addr), 32'h100);
        step();                                   // C16
        #1;
        check("redir_valid_lat", 32'(o_ir_valid), 0);
        check("redir_addr2", 32'(o_mem_addr), 32'h102);
        step();                                   // C17
        i_en = 1'b0;
        #1;
        check("redir_head_valid", 32'(o_ir_valid), 1);
        check("redir_head_ir", 32'(o_ir), 32'h9991);
        check("redir_head_pc", 32'(o_ir_pc), 32'h100);
        check("redir_head_count", 32'(o_count), 1);
        check("en_off_no_read", 32'(o_mem_en), 0);
        step();                                   // C18
        #1;
        check("en_off_inflight_kept", 32'(o_count), 2);
        check("en_off_mem_en", 32'(o_mem_en), 0);
        step();                                   // C19

        // Address wrap at the top of memory.
        i_redirect = 1'b1; i_redirect_addr = 13'h1FFE;
        #1;
        check("wrap_redir_no_read", 32'(o_mem_en), 0);
        step();                                   // C20
        i_redirect = 1'b0; i_en = 1'b1;
        #1;
        check("wrap_count", 32'(o_count), 0);
        check("wrap_idle", 32'(o_mem_en), 0);
        step();                                   // C21
        #1;
        check("wrap_addr0", 32'(o_mem_addr), 32'h1FFE);
        check("wrap_en0", 32'(o_mem_en), 1);
        step();                                   // C22
        #1;
        check("wrap_addr1", 32'(o_mem_addr), 0);
        check("wrap_en1", 32'(o_mem_en), 1);
        step();                                   // C23
        i_redirect = 1'b1; i_redirect_addr = 13'h0200; i_mem_gnt = 1'b0;
        #1;
        check("wrap_head_ir", 32'(o_ir), 32'h1000);
        check("wrap_head_pc", 32'(o_ir_pc), 32'h1FFE);
        step();                                   // C24
        i_redirect = 1'b0; i_ir_ready = 1'b1;
        #1;
        check("toggle_start_count", 32'(o_count), 0);
        step();                                   // C25

        // Grant toggling with decode always ready.
        for (int k = 0; k < 12; k++) begin
            i_mem_gnt = (k < 8) && (k % 2 == 0);
            #1;
            if (k < 8) begin
                check("toggle_mem_en", 32'(o_mem_en), (k % 2 == 0) ? 1 : 0);
                if (k % 2 == 0)
                    check("toggle_addr", 32'(o_mem_addr), 32'h200 + 32'(k));
            end
            if (o_ir_valid) begin
                if (popped < 4) begin
                    check("toggle_pc", 32'(o_ir_pc), 32'h200 + 32'(2 * popped));
                    check("toggle_ir", 32'(o_ir), 32'(exp_toggle[popped]));
                end
                popped++;
            end
            step();
        end
        #1;
        check("toggle_popped", 32'(popped), 4);
        check("toggle_drained", 32'(o_count), 0);

        // Reset while a read is in flight.
        i_mem_gnt = 1'b1; i_ir_ready = 1'b0;
        #1;
        check("rstmid_issue", 32'(o_mem_en), 1);
        check("rstmid_addr", 32'(o_mem_addr), 32'h208);
        step();
        rst = 1'b1;
        #1;
        check("rstmid_mem_en", 32'(o_mem_en), 0);
        check("rstmid_rd_en", 32'(o_mem_rd_en), 0);
        check("rstmid_count", 32'(o_count), 0);
        check("rstmid_valid", 32'(o_ir_valid), 0);
        check("rstmid_ir", 32'(o_ir), 0);
        step();
        rst = 1'b0;
        #1;
        check("rstmid_idle", 32'(o_mem_en), 0);
        step();
        #1;
        check("rstmid_pc_en", 32'(o_mem_en), 1);
        check("rstmid_pc_addr", 32'(o_mem_addr), 0);
        step(); step();
        #1;
        check("rstmid_head_ir", 32'(o_ir), 32'h1111);
        check("rstmid_head_pc", 32'(o_ir_pc), 0);
        check("rstmid_head_count", 32'(o_count), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
